// File: rtl/pwm_sample_feeder.sv
// pwm_sample_feeder: scales and saturates bursty signed samples, buffers them
// in a small FIFO and releases one sample per PWM frame on a held output bus.
module pwm_sample_feeder #(
  parameter int IN_WIDTH          = 16,
  parameter int DATA_WIDTH        = 12,
  parameter int COUNTER_WIDTH     = 10,
  parameter int SHIFT             = 4,
  parameter int FIFO_DEPTH        = 8,
  parameter int HOLD_ON_UNDERFLOW = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [IN_WIDTH-1:0]           SampleIn,
  input  logic                          SampleValid,
  output logic                          SampleReady,
  output logic [DATA_WIDTH-1:0]         DataOut,
  output logic                          FrameStrobe,
  output logic                          Underflow,
  output logic                          Overflow,
  output logic [$clog2(FIFO_DEPTH):0]   FillLevel
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((2**(COUNTER_WIDTH-1)) - 1);
  localparam logic signed [IN_WIDTH-1:0] SAT_MIN = IN_WIDTH'(-(2**(COUNTER_WIDTH-1)));

  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]              count_q, count_d;
  logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    mem_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic                     frame_strobe_q, frame_strobe_d;
  logic                     underflow_q, underflow_d;
  logic                     overflow_q, overflow_d;

  logic signed [IN_WIDTH-1:0] shifted;
  logic signed [IN_WIDTH-1:0] saturated;
  logic [DATA_WIDTH-1:0]      converted;
  logic                       tick;
  logic                       full;
  logic                       empty;
  logic                       do_write;
  logic                       do_pop;

  assign tick        = &cnt_q;
  assign full        = (count_q == DEPTH_L);
  assign empty       = (count_q == '0);
  assign SampleReady = !full && !rst;
  assign do_write    = SampleValid && SampleReady;
  assign do_pop      = tick && !empty;

  assign DataOut     = data_q;
  assign FrameStrobe = frame_strobe_q;
  assign Underflow   = underflow_q;
  assign Overflow    = overflow_q;
  assign FillLevel   = count_q;

  // Shift the incoming sample down and clamp it into the PWM duty range;
  // the clamped value fits DATA_WIDTH so truncation keeps the sign.
  always_comb begin
    shifted   = $signed(SampleIn) >>> SHIFT;
    saturated = shifted;
    if (shifted > SAT_MAX) begin
      saturated = SAT_MAX;
    end else if (shifted < SAT_MIN) begin
      saturated = SAT_MIN;
    end
    converted = saturated[DATA_WIDTH-1:0];
  end

  // Next-state for the frame counter, FIFO bookkeeping and output registers.
  // Emptiness is judged on registered state, so a write landing on a tick
  // into an empty FIFO is not bypassed to the output.
  always_comb begin
    cnt_d          = cnt_q + 1'b1;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    data_d         = data_q;
    frame_strobe_d = 1'b0;
    underflow_d    = 1'b0;
    overflow_d     = SampleValid && !SampleReady;

    if (do_write) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_write && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (!do_write && do_pop) begin
      count_d = count_q - 1'b1;
    end

    if (tick) begin
      frame_strobe_d = 1'b1;
      if (!empty) begin
        data_d = mem_q[rd_ptr_q];
      end else begin
        underflow_d = 1'b1;
        if (HOLD_ON_UNDERFLOW == 0) begin
          data_d = '0;
        end
      end
    end
  end

  // Storage update: only the slot under the write pointer changes.
  always_comb begin
    mem_d = mem_q;
    if (do_write) begin
      mem_d[wr_ptr_q] = converted;
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      data_q         <= '0;
      frame_strobe_q <= 1'b0;
      underflow_q    <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      data_q         <= data_d;
      frame_strobe_q <= frame_strobe_d;
      underflow_q    <= underflow_d;
      overflow_q     <= overflow_d;
    end
  end

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Testbench for pwm_sample_feeder: table of conversion vectors plus directed
// sequences for fill/overflow, underflow hold, tick collisions and reset.
module tb_pwm_sample_feeder;

  typedef struct {
    logic [15:0] sampleIn;
    logic [11:0] expData;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] SampleIn;
  logic        SampleValid;
  logic        SampleReady;
  logic [11:0] DataOut;
  logic        FrameStrobe;
  logic        Underflow;
  logic        Overflow;
  logic [3:0]  FillLevel;

  int checks;
  int failures;
  vec_t vecs[11];

  pwm_sample_feeder dut (
    .clk(clk),
    .rst(rst),
    .SampleIn(SampleIn),
    .SampleValid(SampleValid),
    .SampleReady(SampleReady),
    .DataOut(DataOut),
    .FrameStrobe(FrameStrobe),
    .Underflow(Underflow),
    .Overflow(Overflow),
    .FillLevel(FillLevel)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Present one sample for a single cycle, driven on the falling edge.
  task automatic applyStimulus(input logic [15:0] s);
    SampleIn    = s;
    SampleValid = 1'b1;
    @(negedge clk);
    SampleValid = 1'b0;
  endtask

  // Step falling edges until FrameStrobe is seen; an expired budget is a failure.
  task automatic waitStrobe(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!FrameStrobe && n < 1100);
    if (!FrameStrobe) checkOutput("strobe_timeout", 32'(n), 32'd1024);
  endtask

  // Advance a fixed number of falling edges.
  task automatic stepCycles(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  // Main sequence: reset checks, idle framing, conversion table, then the
  // multi-cycle corner cases.
  initial begin
    int n;
    int ovfCount;
    checks      = 0;
    failures    = 0;
    rst         = 1'b1;
    SampleIn    = '0;
    SampleValid = 1'b0;

    vecs[0]  = '{16'h1000, 12'h100};
    vecs[1]  = '{16'h7FFF, 12'h1FF};
    vecs[2]  = '{16'h8000, 12'hE00};
    vecs[3]  = '{16'hFFFF, 12'hFFF};
    vecs[4]  = '{16'h1FFF, 12'h1FF};
    vecs[5]  = '{16'h2000, 12'h1FF};
    vecs[6]  = '{16'hE000, 12'hE00};
    vecs[7]  = '{16'hDFFF, 12'hE00};
    vecs[8]  = '{16'h000F, 12'h000};
    vecs[9]  = '{16'hFFF0, 12'hFFF};
    vecs[10] = '{16'h0010, 12'h001};

    stepCycles(3);
    checkOutput("rst_ready", 32'(SampleReady), 0);
    checkOutput("rst_data", 32'(DataOut), 0);
    checkOutput("rst_strobe", 32'(FrameStrobe), 0);
    checkOutput("rst_underflow", 32'(Underflow), 0);
    checkOutput("rst_overflow", 32'(Overflow), 0);
    checkOutput("rst_fill", 32'(FillLevel), 0);
    rst = 1'b0;

    waitStrobe(n);
    checkOutput("idle_first_tick", 32'(n), 1024);
    checkOutput("idle_underflow", 32'(Underflow), 1);
    checkOutput("idle_data", 32'(DataOut), 0);
    checkOutput("idle_ready", 32'(SampleReady), 1);
    @(negedge clk);
    checkOutput("idle_strobe_pulse", 32'(FrameStrobe), 0);
    checkOutput("idle_underflow_pulse", 32'(Underflow), 0);
    waitStrobe(n);
    checkOutput("idle_period", 32'(n), 1023);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].sampleIn);
      checkOutput("vec_fill", 32'(FillLevel), 1);
      waitStrobe(n);
      checkOutput("vec_data", 32'(DataOut), 32'(vecs[i].expData));
      checkOutput("vec_no_underflow", 32'(Underflow), 0);
    end

    ovfCount = 0;
    for (int i = 1; i <= 9; i++) begin
      SampleIn    = 16'(i * 16);
      SampleValid = 1'b1;
      @(negedge clk);
      if (Overflow) ovfCount++;
      if (i == 8) begin
        checkOutput("fill_ready_low", 32'(SampleReady), 0);
        checkOutput("fill_level8", 32'(FillLevel), 8);
      end
      if (i == 9) checkOutput("fill_overflow_9th", 32'(Overflow), 1);
    end
    SampleValid = 1'b0;
    @(negedge clk);
    if (Overflow) ovfCount++;
    checkOutput("fill_overflow_once", 32'(ovfCount), 1);
    checkOutput("fill_level_after", 32'(FillLevel), 8);
    for (int i = 1; i <= 8; i++) begin
      waitStrobe(n);
      checkOutput("fill_order", 32'(DataOut), 32'(i));
      checkOutput("fill_no_underflow", 32'(Underflow), 0);
    end
    waitStrobe(n);
    checkOutput("fill_final_underflow", 32'(Underflow), 1);
    checkOutput("fill_final_hold", 32'(DataOut), 8);

    applyStimulus(16'(100 * 16));
    waitStrobe(n);
    checkOutput("uf_data", 32'(DataOut), 100);
    waitStrobe(n);
    checkOutput("uf_underflow", 32'(Underflow), 1);
    checkOutput("uf_hold", 32'(DataOut), 100);

    stepCycles(1023);
    SampleIn    = 16'h0350;
    SampleValid = 1'b1;
    @(negedge clk);
    SampleValid = 1'b0;
    checkOutput("coll_empty_strobe", 32'(FrameStrobe), 1);
    checkOutput("coll_empty_underflow", 32'(Underflow), 1);
    checkOutput("coll_empty_fill", 32'(FillLevel), 1);
    checkOutput("coll_empty_hold", 32'(DataOut), 100);
    waitStrobe(n);
    checkOutput("coll_empty_period", 32'(n), 1024);
    checkOutput("coll_empty_data", 32'(DataOut), 12'h035);
    checkOutput("coll_empty_no_uf", 32'(Underflow), 0);

    for (int i = 1; i <= 8; i++) applyStimulus(16'(i * 32));
    checkOutput("coll_full_level", 32'(FillLevel), 8);
    stepCycles(1023 - 8);
    SampleIn    = 16'h0FF0;
    SampleValid = 1'b1;
    @(negedge clk);
    SampleValid = 1'b0;
    checkOutput("coll_full_strobe", 32'(FrameStrobe), 1);
    checkOutput("coll_full_overflow", 32'(Overflow), 1);
    checkOutput("coll_full_fill", 32'(FillLevel), 7);
    checkOutput("coll_full_data", 32'(DataOut), 2);
    waitStrobe(n);
    checkOutput("coll_full_next", 32'(DataOut), 4);
    waitStrobe(n);
    checkOutput("coll_full_next2", 32'(DataOut), 6);
    checkOutput("coll_full_fill5", 32'(FillLevel), 5);

    stepCycles(10);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_ready", 32'(SampleReady), 0);
    @(negedge clk);
    checkOutput("midrst_fill", 32'(FillLevel), 0);
    checkOutput("midrst_data", 32'(DataOut), 0);
    rst = 1'b0;
    waitStrobe(n);
    checkOutput("midrst_tick", 32'(n), 1024);
    checkOutput("midrst_underflow", 32'(Underflow), 1);
    checkOutput("midrst_data_after", 32'(DataOut), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_sample_feeder.md
# pwm_sample_feeder

Rate adapter sitting directly upstream of the PWM output stage. Accepts bursty signed demodulated samples with a valid strobe, scales and saturates them to the PWM duty-cycle range, and buffers them in a small FIFO. Releases exactly one sample per PWM frame (2^COUNTER_WIDTH clocks) on a held output bus that drives the PWM `DataIn`.

## Interface
- `IN_WIDTH`, 16: width of signed input samples.
- `DATA_WIDTH`, 12: width of `DataOut`; must match the PWM data width.
- `COUNTER_WIDTH`, 10: PWM counter width; sets the frame length to 2^COUNTER_WIDTH clocks and the output range to [-2^(COUNTER_WIDTH-1), 2^(COUNTER_WIDTH-1)-1].
- `SHIFT`, 4: arithmetic right shift applied to input samples before saturation.
- `FIFO_DEPTH`, 8: FIFO entries; power of 2, at least 2.
- `HOLD_ON_UNDERFLOW`, 1: on an empty FIFO at a frame tick, 1 holds the last `DataOut` and 0 forces `DataOut` to 0.
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `SampleIn`, in, IN_WIDTH: signed two's-complement sample.
- `SampleValid`, in, 1: `SampleIn` is valid this cycle.
- `SampleReady`, out, 1: FIFO can accept a sample this cycle.
- `DataOut`, out, DATA_WIDTH: signed sample to the PWM stage; changes only on frame ticks.
- `FrameStrobe`, out, 1: one-cycle pulse, high in the first cycle a new `DataOut` value is visible.
- `Underflow`, out, 1: one-cycle pulse; the FIFO was empty at a frame tick.
- `Overflow`, out, 1: one-cycle pulse; a sample was dropped because `SampleValid` was high while `SampleReady` was low.
- `FillLevel`, out, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Frame counter**
  - Free-running COUNTER_WIDTH-bit counter, reset to 0, wraps naturally.
  - A frame tick occurs in the cycle where the counter equals 2^COUNTER_WIDTH-1.
- **Conversion** (applied at write time)
  - Compute `SampleIn >>> SHIFT` (arithmetic shift, floor rounding).
  - Saturate to [-2^(COUNTER_WIDTH-1), 2^(COUNTER_WIDTH-1)-1].
  - Sign-extend to DATA_WIDTH and store in the FIFO.
- **Write**
  - A sample is accepted when `SampleValid` and `SampleReady` are both high.
  - When `SampleValid` is high and `SampleReady` is low, the sample is discarded and `Overflow` pulses. Upstream never stalls.
- **SampleReady**
  - Equals !full, computed from registered state.
  - A pop in the same cycle does not make room for that cycle's write. Full plus valid always drops.
  - `SampleReady` is 0 while `rst` is high.
- **Read** at a frame tick:
  - FIFO non-empty: pop the head into `DataOut`.
  - FIFO empty: `Underflow` pulses, and `DataOut` either holds its value (`HOLD_ON_UNDERFLOW`=1) or is set to 0 (`HOLD_ON_UNDERFLOW`=0).
  - `FrameStrobe` pulses at every frame tick, whether the FIFO was empty or not.
- **Simultaneous write and frame tick**
  - On an empty FIFO there is no bypass. The tick underflows, and the written sample is popped at the next tick.
  - On a partially filled FIFO, the write and the pop both occur and `FillLevel` is unchanged.
- **Ordering:** strict FIFO order, and no sample is duplicated.

## Timing
- **Reset values:** `DataOut`=0, `FrameStrobe`=0, `Underflow`=0, `Overflow`=0, `SampleReady`=0, `FillLevel`=0. The FIFO is empty and the frame counter is 0.
- **Reset mid-operation:** FIFO contents are flushed and lost. The frame counter restarts at 0 on the first cycle after `rst` falls.
- **First tick:** the first frame tick after reset release is in cycle 2^COUNTER_WIDTH-1, counting cycle 0 as the first cycle with `rst` low.
- **Write latency:** a sample accepted at edge t is reflected in `FillLevel` after t+1 and is eligible for the first frame tick at or after t+1.
- **Output registers:** `DataOut`, `FrameStrobe`, and `Underflow` update on the frame-tick edge and become visible together in the following cycle.
- **Overflow:** registered, and visible in the cycle after the dropped sample.
- **Throughput:** up to 1 write per clock and 1 read per frame.

## Test plan
- **Idle after reset:** release reset with no input -> `DataOut` stays 0; `FrameStrobe` and `Underflow` pulse together every 1024 cycles, the first visible at cycle 1024.
- **Scaling and saturation:** write `SampleIn` values 0x1000, 0x7FFF, 0x8000, 0xFFFF on successive frames -> `DataOut` shows 0x100, 0x1FF, 0xE00, 0xFFF on consecutive frame ticks.
- **Fill and overflow:** write 9 back-to-back samples (1..9 ×16) between ticks -> `SampleReady` is low after the 8th, `Overflow` pulses once for the 9th, `FillLevel`=8; the next 8 ticks output 1..8 in order, then `Underflow`.
- **Underflow behaviour:** a single sample of 100×16 -> `DataOut`=100, then at the next tick `Underflow` pulses and `DataOut` stays 100 (`HOLD_ON_UNDERFLOW`=1) or becomes 0 (`HOLD_ON_UNDERFLOW`=0).
- **Collision, empty FIFO:** write on the exact frame-tick cycle with the FIFO empty -> `Underflow` pulses; the sample appears on `DataOut` one frame later.
- **Collision, full FIFO, and reset mid-operation:** write on a tick with the FIFO full -> the sample is dropped and `Overflow` pulses. Then assert `rst` with `FillLevel`=5 -> `FillLevel`=0, `DataOut`=0, and the next tick occurs 1023 cycles after release.
